// File: rtl/mfcc_feature_buffer_if.sv
// Interface bundling the MFCC input stream, window request and feature output stream
// of mfcc_feature_buffer. The master side is the surrounding system (accelerator,
// classifier). The slave side is the buffer itself.
interface mfcc_feature_buffer_if #(
    parameter int DW = 32
);
    logic [DW-1:0] mfcc_in;
    logic          mfcc_valid;
    logic [7:0]    num_mfcc_coeffs;
    logic          window_ready;
    logic          rd_start;
    logic [DW-1:0] feat_out;
    logic          feat_valid;
    logic          feat_ready;
    logic          feat_last;
    logic          overrun;

    modport master (
        output mfcc_in, mfcc_valid, num_mfcc_coeffs, rd_start, feat_ready,
        input  window_ready, feat_out, feat_valid, feat_last, overrun
    );

    modport slave (
        input  mfcc_in, mfcc_valid, num_mfcc_coeffs, rd_start, feat_ready,
        output window_ready, feat_out, feat_valid, feat_last, overrun
    );
endinterface

// File: rtl/mfcc_feature_buffer.sv
// mfcc_feature_buffer
//   Packs the serial MFCC coefficient stream into frames. It keeps the last NUM_FRAMES
//   complete frames in a ring of NUM_FRAMES+1 slots. On request, it streams that window
//   oldest-first over a valid/ready handshake.
//   Optional build macro MFCC_SAT16_EN: each coefficient is saturated to signed 16 bits
//   before storage. The ring is then 16 bits wide, and words are sign-extended on readout.
module mfcc_feature_buffer #(
    parameter int MAX_COEFFS = 13,
    parameter int NUM_FRAMES = 49,
    parameter int DW         = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mfcc_feature_buffer_if.slave bus
);

    localparam int S  = NUM_FRAMES + 1;
    localparam int SW = (S > 1) ? $clog2(S) : 1;
    localparam int CW = (MAX_COEFFS > 1) ? $clog2(MAX_COEFFS) : 1;
    localparam int FW = $clog2(NUM_FRAMES + 1);

    localparam logic [SW:0] S_EXT = (SW + 1)'(S);

`ifdef MFCC_SAT16_EN
    localparam int RW = 16;
    localparam logic signed [DW-1:0] SAT_MAX = DW'(32767);
    localparam logic signed [DW-1:0] SAT_MIN = DW'(-32768);

    function automatic logic [RW-1:0] store_word(input logic [DW-1:0] w);
        if ($signed(w) > SAT_MAX) begin
            return 16'h7FFF;
        end else if ($signed(w) < SAT_MIN) begin
            return 16'h8000;
        end else begin
            return w[RW-1:0];
        end
    endfunction

    function automatic logic [DW-1:0] expand_word(input logic [RW-1:0] r);
        return {{(DW - RW){r[RW-1]}}, r};
    endfunction
`else
    localparam int RW = DW;

    function automatic logic [RW-1:0] store_word(input logic [DW-1:0] w);
        return w;
    endfunction

    function automatic logic [DW-1:0] expand_word(input logic [RW-1:0] r);
        return r;
    endfunction
`endif

    typedef logic [SW-1:0] slot_t;
    typedef logic [CW-1:0] col_t;
    typedef logic [FW-1:0] fcnt_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_t;

    function automatic slot_t slot_inc(input slot_t s);
        return (s == slot_t'(S - 1)) ? slot_t'(0) : s + slot_t'(1);
    endfunction

    // Frame storage: one row of MAX_COEFFS words per slot.
    logic [RW-1:0] ring [0:S-1][0:MAX_COEFFS-1];

    state_t        state_q, state_d;
    slot_t         wr_slot_q, wr_slot_d;
    col_t          col_q, col_d;
    logic [7:0]    nc_q, nc_d;
    fcnt_t         frame_cnt_q, frame_cnt_d;
    slot_t         rd_slot_q, rd_slot_d;
    col_t          rd_col_q, rd_col_d;
    fcnt_t         rd_frm_q, rd_frm_d;
    logic [7:0]    rd_nc_q, rd_nc_d;
    logic          fetch_done_q, fetch_done_d;
    logic [DW-1:0] feat_out_q, feat_out_d;
    logic          feat_valid_q, feat_valid_d;
    logic          feat_last_q, feat_last_d;
    logic          overrun_q, overrun_d;
    logic          window_ready_q, window_ready_d;

    logic          wr_en;
    logic          rd_en;
    logic [7:0]    nc_in;
    logic [7:0]    frame_nc;
    fcnt_t         cnt_base;
    logic [SW:0]   slot_dist;
    logic          slot_unread;
    logic          drop;
    logic          last_col;
    logic          last_frm;

    // Next-state logic for the write packer, the collision guard and the read FSM.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path leaves
        // one unassigned and no latch is inferred.
        state_d      = state_q;
        wr_slot_d    = wr_slot_q;
        col_d        = col_q;
        nc_d         = nc_q;
        frame_cnt_d  = frame_cnt_q;
        rd_slot_d    = rd_slot_q;
        rd_col_d     = rd_col_q;
        rd_frm_d     = rd_frm_q;
        rd_nc_d      = rd_nc_q;
        fetch_done_d = fetch_done_q;
        feat_out_d   = feat_out_q;
        feat_valid_d = feat_valid_q;
        feat_last_d  = feat_last_q;
        overrun_d    = overrun_q;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        cnt_base     = frame_cnt_q;
        last_col     = 1'b0;
        last_frm     = 1'b0;

        // Out-of-range frame sizes fall back to the full row width.
        nc_in = ((bus.num_mfcc_coeffs == 8'd0) || (bus.num_mfcc_coeffs > 8'(MAX_COEFFS)))
              ? 8'(MAX_COEFFS) : bus.num_mfcc_coeffs;
        // The frame size is taken from the input only on the first word of a frame.
        frame_nc = (col_q == col_t'(0)) ? nc_in : nc_q;

        // A slot is still owed to the reader if it lies between the fetch pointer and
        // the end of the window (distance measured forward around the ring).
        slot_dist = (wr_slot_q >= rd_slot_q)
                  ? ({1'b0, wr_slot_q} - {1'b0, rd_slot_q})
                  : ({1'b0, wr_slot_q} + S_EXT - {1'b0, rd_slot_q});
        slot_unread = (state_q == ST_READ) && !fetch_done_q &&
                      ((int'(slot_dist) + int'(rd_frm_q)) <= (NUM_FRAMES - 1));
        drop = bus.mfcc_valid && slot_unread;

        // Write side: pack words into the current slot. A frame-size change discards
        // the history, because old frames no longer match the new row length.
        if (bus.mfcc_valid) begin
            if (drop) begin
                overrun_d = 1'b1;
            end else begin
                wr_en = 1'b1;
                if (col_q == col_t'(0)) begin
                    nc_d = nc_in;
                    if (nc_in != nc_q) begin
                        cnt_base = fcnt_t'(0);
                    end
                end
                if (8'(col_q) == (frame_nc - 8'd1)) begin
                    col_d       = col_t'(0);
                    wr_slot_d   = slot_inc(wr_slot_q);
                    frame_cnt_d = (cnt_base == fcnt_t'(NUM_FRAMES)) ? cnt_base
                                                                     : cnt_base + fcnt_t'(1);
                end else begin
                    col_d       = col_q + col_t'(1);
                    frame_cnt_d = cnt_base;
                end
            end
        end

        // Read side. In IDLE, wait for an accepted request. In READ, keep the output
        // register full while the consumer accepts.
        case (state_q)
            ST_IDLE: begin
                if (bus.rd_start && window_ready_q) begin
                    state_d      = ST_READ;
                    rd_slot_d    = slot_inc(wr_slot_q);
                    rd_col_d     = col_t'(0);
                    rd_frm_d     = fcnt_t'(0);
                    rd_nc_d      = nc_q;
                    fetch_done_d = 1'b0;
                end
            end
            ST_READ: begin
                if (feat_valid_q && bus.feat_ready) begin
                    feat_valid_d = 1'b0;
                    feat_last_d  = 1'b0;
                    if (feat_last_q) begin
                        state_d = ST_IDLE;
                    end
                end
                if (!fetch_done_q && (!feat_valid_q || bus.feat_ready)) begin
                    rd_en        = 1'b1;
                    last_col     = (8'(rd_col_q) == (rd_nc_q - 8'd1));
                    last_frm     = (rd_frm_q == fcnt_t'(NUM_FRAMES - 1));
                    feat_valid_d = 1'b1;
                    feat_last_d  = last_col && last_frm;
                    if (last_col) begin
                        rd_col_d  = col_t'(0);
                        rd_frm_d  = rd_frm_q + fcnt_t'(1);
                        rd_slot_d = slot_inc(rd_slot_q);
                        if (last_frm) begin
                            fetch_done_d = 1'b1;
                        end
                    end else begin
                        rd_col_d = rd_col_q + col_t'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (rd_en) begin
            feat_out_d = expand_word(ring[rd_slot_q][rd_col_q]);
        end

        window_ready_d = (state_d == ST_IDLE) && (frame_cnt_d == fcnt_t'(NUM_FRAMES));
    end

    // Control state, pointers and the registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated with non-blocking assignments only, so all
        // flops sample their _d values from before the clock edge.
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            wr_slot_q      <= slot_t'(0);
            col_q          <= col_t'(0);
            nc_q           <= 8'd0;
            frame_cnt_q    <= fcnt_t'(0);
            rd_slot_q      <= slot_t'(0);
            rd_col_q       <= col_t'(0);
            rd_frm_q       <= fcnt_t'(0);
            rd_nc_q        <= 8'd0;
            fetch_done_q   <= 1'b0;
            feat_out_q     <= '0;
            feat_valid_q   <= 1'b0;
            feat_last_q    <= 1'b0;
            overrun_q      <= 1'b0;
            window_ready_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_slot_q      <= wr_slot_d;
            col_q          <= col_d;
            nc_q           <= nc_d;
            frame_cnt_q    <= frame_cnt_d;
            rd_slot_q      <= rd_slot_d;
            rd_col_q       <= rd_col_d;
            rd_frm_q       <= rd_frm_d;
            rd_nc_q        <= rd_nc_d;
            fetch_done_q   <= fetch_done_d;
            feat_out_q     <= feat_out_d;
            feat_valid_q   <= feat_valid_d;
            feat_last_q    <= feat_last_d;
            overrun_q      <= overrun_d;
            window_ready_q <= window_ready_d;
        end
    end

    // Ring write port.
    always_ff @(posedge clk) begin
        // NOTE: the ring has no reset. A slot is only read after frame_cnt confirms that
        // it was written, so clearing the storage would only cost reset fan-out.
        if (wr_en) begin
            ring[wr_slot_q][col_q] <= store_word(bus.mfcc_in);
        end
    end

    assign bus.window_ready = window_ready_q;
    assign bus.feat_out     = feat_out_q;
    assign bus.feat_valid   = feat_valid_q;
    assign bus.feat_last    = feat_last_q;
    assign bus.overrun      = overrun_q;

endmodule
